// File: rtl/memory_pkg.sv
// Shared definitions for the word-organised RAM.
// Holds the default geometry, the active-low strobe levels, and the access
// operation decoded from the CS/WE strobes.
package memory_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_BITS_DEF  = 10;
    localparam int unsigned ADDR_WIDTH     = 32;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    // WE picks exactly one operation per selected edge; CS high means idle.
    function automatic op_t decode_op(input logic cs, input logic we);
        if (cs != STROBE_ON) begin
            return OP_IDLE;
        end
        return (we == STROBE_ON) ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/memory_array.sv
// DEPTH x DATA_WIDTH storage with asynchronous clear, one write port and one
// synchronous read port.
// Ports: clock, reset (async, active high), we (write strobe), re (read
// strobe), rzero (load zero into the read register), addr, wdata, rdata.
module memory_array
    import memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic                  rzero,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage: whole array cleared on reset so contents are never unknown.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: holds its value on idle and write edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (rzero) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory.sv
// Word-organised synchronous RAM with an SRAM-style bidirectional bus.
// Ports: clock, reset (async, active high), Address (word address),
// Data (inout, driven only while CS=0, OE=0, WE=1), CS/WE/OE (active low).
// Optional MEMORY_RANGE_ERR_EN adds AddrError: one-cycle pulse after any
// selected access whose Address is at or beyond DEPTH.
module memory
    import memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    inout  wire  [DATA_WIDTH-1:0] Data,
    input  logic                  CS,
    input  logic                  WE,
    input  logic                  OE
`ifdef MEMORY_RANGE_ERR_EN
    ,
    output logic                  AddrError
`endif
);

    op_t                   op;
    logic                  in_range;
    logic                  drive_c;
    logic [DATA_WIDTH-1:0] rdata;

    assign op = decode_op(CS, WE);

    // Full-width check so upper address bits never alias into the array.
    assign in_range = (Address[ADDR_WIDTH-1:ADDR_BITS] == '0);

    memory_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    ((op == OP_WRITE) && in_range),
        .re    ((op == OP_READ) && in_range),
        .rzero ((op == OP_READ) && !in_range),
        .addr  (Address[ADDR_BITS-1:0]),
        .wdata (Data),
        .rdata (rdata)
    );

    // Bus driver follows the strobes combinationally; reset releases it at once.
    assign drive_c = !reset && (CS == STROBE_ON) && (OE == STROBE_ON) && (WE == STROBE_OFF);
    assign Data    = drive_c ? rdata : 'z;

`ifdef MEMORY_RANGE_ERR_EN
    // Error pulse: set only on the edge that follows an out-of-range access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            AddrError <= 1'b0;
        end else begin
            AddrError <= (op != OP_IDLE) && !in_range;
        end
    end
`endif

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: vector table plus hand sequences for reset,
// bus release and back-to-back traffic. Reads push expected data to a queue
// that is popped when the word appears on the bus one edge later.
module tb_memory;

    localparam int unsigned DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic        cs = 1'b1;
    logic        we = 1'b1;
    logic        oe = 1'b1;
    logic        drv_en = 1'b0;
    logic [31:0] drv_val = '0;
    wire  [31:0] data_bus;
`ifdef MEMORY_RANGE_ERR_EN
    logic        addr_error;
`endif

    assign data_bus = drv_en ? drv_val : 'z;

    memory dut (
        .clock     (clock),
        .reset     (reset),
        .Address   (address),
        .Data      (data_bus),
        .CS        (cs),
        .WE        (we),
        .OE        (oe)
`ifdef MEMORY_RANGE_ERR_EN
        ,
        .AddrError (addr_error)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        cs;
        logic        we;
        logic        oe;
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    logic [31:0] mem_model [DEPTH];
    logic [31:0] exp_q [$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        exp_q.delete();
    endtask

    // One access: drive at negedge, model it, then check just after the edge.
    task automatic do_op(input logic c, input logic w, input logic o,
                         input logic [31:0] a, input logic [31:0] d, input string name);
        logic        is_read;
        logic [31:0] exp_rd;
        @(negedge clock);
        cs      = c;
        we      = w;
        oe      = o;
        address = a;
        drv_en  = (w == 1'b0);
        drv_val = d;
        is_read = (c == 1'b0) && (w == 1'b1);
        if (c == 1'b0 && w == 1'b0 && a < DEPTH) mem_model[a[9:0]] = d;
        if (is_read) exp_q.push_back((a < DEPTH) ? mem_model[a[9:0]] : 32'h0);
        @(posedge clock);
        #1;
        if (is_read) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s: got empty scoreboard expected one entry", name);
            end else begin
                exp_rd = exp_q.pop_front();
                if (o == 1'b0) check(name, data_bus, exp_rd);
            end
        end else if (w == 1'b0 && o == 1'b0) begin
            // Memory must stay off the bus; any drive would corrupt the writer's value.
            check({name, "_bus"}, data_bus, d);
        end
`ifdef MEMORY_RANGE_ERR_EN
        check({name, "_err"}, {31'h0, addr_error}, {31'h0, (c == 1'b0) && (a >= DEPTH)});
`endif
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0033};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0005, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h1111_1111};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0077};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0000_03FF, 32'h0};

        clear_model();
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state: array and error flag cleared.
`ifdef MEMORY_RANGE_ERR_EN
        check("rst_err", {31'h0, addr_error}, 32'h0);
`endif
        do_op(1'b0, 1'b1, 1'b0, 32'd0, 32'h0, "rst_rd0");
        do_op(1'b0, 1'b1, 1'b0, 32'd1023, 32'h0, "rst_rd1023");

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].cs, vecs[i].we, vecs[i].oe, vecs[i].addr, vecs[i].wdata,
                  $sformatf("vec%0d", i));
        end

        // OE release: with rdata=0x33 on the bus, raising OE must free it at once.
        do_op(1'b0, 1'b1, 1'b0, 32'd0, 32'h0, "oe_rd");
        oe      = 1'b1;
        drv_en  = 1'b1;
        drv_val = 32'h0;
        #1;
        check("oe_release", data_bus, 32'h0);
        drv_en = 1'b0;
        oe     = 1'b0;
        #1;
        check("oe_redrive", data_bus, 32'h0000_0033);
        cs      = 1'b1;
        drv_en  = 1'b1;
        #1;
        check("cs_release", data_bus, 32'h0);
        drv_en = 1'b0;

        // Back-to-back writes then reads: one-cycle latency, no gaps.
        for (int i = 0; i < 8; i++) do_op(1'b0, 1'b0, 1'b1, 32'(i), 32'(i * 3), $sformatf("b2b_wr%0d", i));
        for (int i = 0; i < 8; i++) do_op(1'b0, 1'b1, 1'b0, 32'(i), 32'h0, $sformatf("b2b_rd%0d", i));

        // Mid-cycle reset with the bus driven: release is immediate.
        do_op(1'b0, 1'b1, 1'b0, 32'd7, 32'h0, "pre_rst_rd");
        #2;
        reset   = 1'b1;
        drv_en  = 1'b1;
        drv_val = 32'h0;
        #1;
        check("rst_bus_release", data_bus, 32'h0);

        // A write held across a reset edge is lost.
        @(negedge clock);
        cs      = 1'b0;
        we      = 1'b0;
        oe      = 1'b1;
        address = 32'd2;
        drv_val = 32'h0000_0099;
        @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        cs     = 1'b1;
        drv_en = 1'b0;
        clear_model();
        do_op(1'b0, 1'b1, 1'b0, 32'd2, 32'h0, "rst_lost_wr");
        do_op(1'b0, 1'b1, 1'b0, 32'd5, 32'h0, "rst_clr5");
        do_op(1'b0, 1'b1, 1'b0, 32'd7, 32'h0, "rst_clr7");

        // Error pulse lasts exactly one cycle.
        do_op(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, "oor_rd");
        do_op(1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h0, "idle_after_oor");

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
